seq_divider: RTL

Parametrised sequential restoring divider with an integrated controller: one `start` pulse captures the operands, and the block runs one shift/subtract step per clock. It returns quotient and remainder with a one-cycle `done` pulse. It adds signed mode, divide-by-zero and overflow detection, and a start/busy/done handshake, and sits beside the ALU as the shared multi-cycle divide unit.

---
 rtl/divider_pkg.sv | 22 ++
 rtl/div_step.sv | 25 ++
 rtl/seq_divider.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the sequential divider: state encoding and a negation helper.
package divider_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StRun  = RUN,
    StFin  = FIN
  } state_e;

  // Widest operand the negation helper supports; callers zero-extend and truncate.
  localparam int unsigned NegW = 64;

  // Two's-complement negation; the result truncated to any width <= NegW is exact.
  function automatic logic [NegW-1:0] neg(input logic [NegW-1:0] v);
    return ~v + NegW'(1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step
  import divider_pkg::*;
#(
  parameter int unsigned nBit = 8
) (
  input  logic [nBit:0]   rem_in,
  input  logic            dvd_msb,
  input  logic [nBit-1:0] divisor,
  output logic [nBit:0]   rem_out,
  output logic            q_bit
);

  logic [nBit+1:0] shifted;
  logic [nBit+1:0] diff;

  // Extra top bit of diff acts as the borrow / sign of the trial subtraction.
  always_comb begin
    shifted = {rem_in, dvd_msb};
    diff    = shifted - {2'b00, divisor};
    q_bit   = ~diff[nBit+1];
    rem_out = q_bit ? diff[nBit:0] : shifted[nBit:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider with signed mode, divide-by-zero and overflow flags.
// nBit is limited to the width of the package negation helper (64).
module seq_divider
  import divider_pkg::*;
#(
  parameter int unsigned nBit = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            signed_op,
  input  logic [nBit-1:0] A,
  input  logic [nBit-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [nBit-1:0] Q,
  output logic [nBit-1:0] R,
  output logic            dz,
  output logic            ovf
);

  localparam int unsigned CntW = $clog2(nBit + 1);
  localparam logic [nBit-1:0] MinVal = {1'b1, {(nBit-1){1'b0}}};

  function automatic logic [nBit-1:0] neg_n(input logic [nBit-1:0] v);
    logic [NegW-1:0] t;
    t = neg(NegW'(v));
    return t[nBit-1:0];
  endfunction

  state_e          state_q, state_d;
  logic [nBit:0]   prem_q, prem_d;      // partial remainder
  logic [nBit-1:0] dvd_q, dvd_d;        // dividend in, quotient bits shift in from the right
  logic [nBit-1:0] bmag_q, bmag_d;
  logic [nBit-1:0] araw_q, araw_d;      // raw dividend, returned as R on divide by zero
  logic            qsign_q, qsign_d;
  logic            rsign_q, rsign_d;
  logic            dz_pend_q, dz_pend_d;
  logic            ovf_pend_q, ovf_pend_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [nBit-1:0] quo_q, quo_d;
  logic [nBit-1:0] rem_q, rem_d;
  logic            done_q, done_d;
  logic            dz_q, dz_d;
  logic            ovf_q, ovf_d;

  logic [nBit:0]   step_rem;
  logic            step_qbit;

  div_step #(
    .nBit (nBit)
  ) u_step (
    .rem_in  (prem_q),
    .dvd_msb (dvd_q[nBit-1]),
    .divisor (bmag_q),
    .rem_out (step_rem),
    .q_bit   (step_qbit)
  );

  // Next-state logic: operand capture, iteration and sign correction.
  always_comb begin
    state_d    = state_q;
    prem_d     = prem_q;
    dvd_d      = dvd_q;
    bmag_d     = bmag_q;
    araw_d     = araw_q;
    qsign_d    = qsign_q;
    rsign_d    = rsign_q;
    dz_pend_d  = dz_pend_q;
    ovf_pend_d = ovf_pend_q;
    cnt_d      = cnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    dz_d       = dz_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          dvd_d      = (signed_op && A[nBit-1]) ? neg_n(A) : A;
          bmag_d     = (signed_op && B[nBit-1]) ? neg_n(B) : B;
          qsign_d    = signed_op && (A[nBit-1] ^ B[nBit-1]);
          rsign_d    = signed_op && A[nBit-1];
          araw_d     = A;
          prem_d     = '0;
          cnt_d      = '0;
          dz_pend_d  = (B == '0);
          ovf_pend_d = signed_op && (A == MinVal) && (B == {nBit{1'b1}});
          state_d    = (B == '0) ? StFin : StRun;
        end
      end
      StRun: begin
        prem_d = step_rem;
        dvd_d  = {dvd_q[nBit-2:0], step_qbit};
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(nBit - 1)) begin
          state_d = StFin;
        end
      end
      StFin: begin
        if (dz_pend_q) begin
          quo_d = '1;
          rem_d = araw_q;
          dz_d  = 1'b1;
          ovf_d = 1'b0;
        end else begin
          // min / -1 falls out naturally: magnitude 2^(nBit-1) negates to itself.
          quo_d = qsign_q ? neg_n(dvd_q) : dvd_q;
          rem_d = rsign_q ? neg_n(prem_q[nBit-1:0]) : prem_q[nBit-1:0];
          dz_d  = 1'b0;
          ovf_d = ovf_pend_q;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      prem_q     <= '0;
      dvd_q      <= '0;
      bmag_q     <= '0;
      araw_q     <= '0;
      qsign_q    <= 1'b0;
      rsign_q    <= 1'b0;
      dz_pend_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prem_q     <= prem_d;
      dvd_q      <= dvd_d;
      bmag_q     <= bmag_d;
      araw_q     <= araw_d;
      qsign_q    <= qsign_d;
      rsign_q    <= rsign_d;
      dz_pend_q  <= dz_pend_d;
      ovf_pend_q <= ovf_pend_d;
      cnt_q      <= cnt_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      done_q     <= done_d;
      dz_q       <= dz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign Q    = quo_q;
  assign R    = rem_q;
  assign dz   = dz_q;
  assign ovf  = ovf_q;

endmodule
